// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module  : addsub_pkg
// Brief   : Shared state encoding and default widths for the add/sub sequencer
// Rev     : 1.0
// ============================================================================
package addsub_pkg;

  localparam int N_DEFAULT = 64;
  localparam int W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : addsub_pkg
`default_nettype wire

// File: rtl/addsub_slice.sv
`default_nettype none
// ============================================================================
// Module  : addsub_slice
// Brief   : W-bit combinational adder with carry in/out, reused every RUN cycle
// Rev     : 1.0
// ============================================================================
module addsub_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] w_full;

  assign w_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign sum    = w_full[W-1:0];
  assign cout   = w_full[W];

endmodule : addsub_slice
`default_nettype wire

// File: rtl/addsub_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : addsub_seq_ctrl
// Brief   : N-bit signed add/sub computed W bits per cycle through one slice
// Rev     : 1.0
// ============================================================================
module addsub_seq_ctrl
  import addsub_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         k,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   s,
  output logic         cout
);

  localparam int SLICES = N / W;
  localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [N-1:0]     r_a;
  logic [N-1:0]     r_bx;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic [N:0]       r_s;
  logic             r_cout;
  logic [W-1:0]     w_slice_sum;
  logic             w_slice_cout;
  logic             w_accept;
  logic             w_last;

  assign w_accept = (r_state == IDLE) && in_valid && !flush;
  assign w_last   = (r_idx == LAST_IDX);

  addsub_slice #(.W(W)) u_slice (
    .a    (r_a[r_idx*W +: W]),
    .b    (r_bx[r_idx*W +: W]),
    .cin  (r_carry),
    .sum  (w_slice_sum),
    .cout (w_slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (in_valid)  w_next = RUN;
        RUN:     if (w_last)    w_next = DONE;
        DONE:    if (out_ready) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  // Subtraction is A + ~B + 1: B is inverted on capture and k seeds the carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_bx    <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
    end else if (flush) begin
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_bx    <= b ^ {N{k}};
      r_carry <= k;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_s[r_idx*W +: W] <= w_slice_sum;
      r_carry           <= w_slice_cout;
      if (w_last) begin
        // Sign bit of the (N+1)-bit result from the sign-extended operands.
        r_s[N] <= r_a[N-1] ^ r_bx[N-1] ^ w_slice_cout;
        r_cout <= w_slice_cout;
        r_idx  <= '0;
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  assign s    = r_s;
  assign cout = r_cout;

endmodule : addsub_seq_ctrl
`default_nettype wire

// File: tb/tb_addsub_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_addsub_seq_ctrl
// Brief   : Self-checking bench: directed vectors, corner sequences, random ops
// Rev     : 1.0
// ============================================================================
module tb_addsub_seq_ctrl;

  localparam int N = 64;
  localparam int W = 16;
  localparam int LAT = N / W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         k = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N:0]   s;
  logic         cout;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         k;
    logic [N:0]   s;
    logic         c;
  } vec_t;

  vec_t vecs[4];

  addsub_seq_ctrl #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .k         (k),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [N:0] act, input logic [N:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: signed arithmetic on sign-extended operands, unsigned carry rule.
  function automatic logic [N:0] model_s(input logic [N-1:0] ma, input logic [N-1:0] mb, input logic mk);
    logic signed [N:0] sa, sb;
    sa = {ma[N-1], ma};
    sb = {mb[N-1], mb};
    return mk ? (sa - sb) : (sa + sb);
  endfunction

  function automatic logic model_c(input logic [N-1:0] ma, input logic [N-1:0] mb, input logic mk);
    logic [N:0] u;
    u = {1'b0, ma} + {1'b0, mb};
    return mk ? (ma >= mb) : u[N];
  endfunction

  // Entered #1 after a rising edge with the block idle; returns at DONE.
  task automatic start_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic tk,
                          output int lat);
    a = ta; b = tb_v; k = tk; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic run_and_check(input string nm, input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                               input logic tk, input logic [N:0] es, input logic ec);
    int lat;
    start_op(ta, tb_v, tk, lat);
    chk({nm, "_lat"}, (N+1)'(lat), (N+1)'(LAT));
    chk({nm, "_s"}, s, es);
    chk({nm, "_cout"}, (N+1)'(cout), (N+1)'(ec));
    drain();
    chk({nm, "_idle"}, (N+1)'({in_ready, out_valid}), (N+1)'(2'b10));
  endtask

  initial begin
    logic [N:0] held;
    logic [N-1:0] ra, rb;
    logic rk;
    int lat;

    vecs[0] = '{a: 64'd5, b: 64'd3, k: 1'b0, s: 65'd8, c: 1'b0};
    vecs[1] = '{a: 64'd5, b: 64'd7, k: 1'b1, s: 65'h1_FFFF_FFFF_FFFF_FFFE, c: 1'b0};
    vecs[2] = '{a: 64'h7FFF_FFFF_FFFF_FFFF, b: 64'd1, k: 1'b0, s: 65'h0_8000_0000_0000_0000, c: 1'b0};
    vecs[3] = '{a: 64'h8000_0000_0000_0000, b: 64'd1, k: 1'b1, s: 65'h1_7FFF_FFFF_FFFF_FFFF, c: 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s", s, '0);
    chk("rst_cout", (N+1)'(cout), '0);
    chk("rst_out_valid", (N+1)'(out_valid), '0);
    chk("rst_in_ready", (N+1)'(in_ready), (N+1)'(1));
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].k, vecs[i].s, vecs[i].c);
    chk("idle_hold_s", s, vecs[3].s);

    // Backpressure in DONE with a competing request
    start_op(64'd20, 64'd22, 1'b0, lat);
    held = s;
    a = 64'd1000; b = 64'd1; k = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_s", s, held);
      chk("bp_state", (N+1)'({in_ready, out_valid}), (N+1)'(2'b01));
    end
    in_valid = 1'b0;
    drain();
    chk("bp_release", (N+1)'({in_ready, out_valid}), (N+1)'(2'b10));
    chk("bp_value", s, 65'd42);

    // Asynchronous reset after two RUN cycles
    a = 64'd100; b = 64'd1; k = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_s", s, '0);
    chk("arst_out_valid", (N+1)'(out_valid), '0);
    @(posedge clk); #1 rst_n = 1'b1;
    chk("arst_in_ready", (N+1)'(in_ready), (N+1)'(1));
    @(posedge clk); #1;
    run_and_check("after_rst", 64'd10, 64'd4, 1'b1, 65'd6, 1'b1);

    // Flush after two RUN cycles; s holds 6 beforehand so clearing is visible
    a = 64'd100; b = 64'd1; k = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_run_s", s, '0);
    chk("flush_run_state", (N+1)'({in_ready, out_valid, cout}), (N+1)'(3'b100));
    run_and_check("after_flush", 64'd10, 64'd4, 1'b1, 65'd6, 1'b1);

    // Flush in DONE beats out_ready and in_valid
    start_op(64'd3, 64'd3, 1'b1, lat);
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1 flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    chk("flush_done_s", s, '0);
    @(posedge clk); #1;
    chk("flush_done_state", (N+1)'({in_ready, out_valid}), (N+1)'(2'b10));

    // Random operations against the reference model
    for (int i = 0; i < 24; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rk = 1'($urandom_range(0, 1));
      if (i % 6 == 0) ra = {1'b1, {(N-1){1'b0}}};
      if (i % 6 == 1) rb = ra;
      start_op(ra, rb, rk, lat);
      chk("rnd_lat", (N+1)'(lat), (N+1)'(LAT));
      chk("rnd_s", s, model_s(ra, rb, rk));
      chk("rnd_cout", (N+1)'(cout), (N+1)'(model_c(ra, rb, rk)));
      held = s;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1 chk("rnd_hold", s, held);
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_addsub_seq_ctrl
`default_nettype wire

// File: doc/addsub_seq_ctrl.md
ADDSUB_SEQ_CTRL -- requirements
Module: addsub_seq_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 64, meaning operand width in bits (N multiple of W, N >= W).
REQ-002 The block SHALL have parameter W, default 16, meaning width of the add/sub slice that is sequenced per cycle.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: port clk, input, 1, rising-edge clock.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port flush, input, 1, synchronous abort of any in-flight operation.
REQ-006 Port in_valid, input, 1, request carries a valid operation.
REQ-007 Port in_ready, output, 1, block can accept a request.
REQ-008 Port a, input, N, signed operand A.
REQ-009 Port b, input, N, signed operand B.
REQ-010 Port k, input, 1, operation select (0 = A+B, 1 = A-B).
REQ-011 Port out_valid, output, 1, result available.
REQ-012 Port out_ready, input, 1, consumer accepts result.
REQ-013 Port s, output, N+1, signed result, never overflows.
REQ-014 Port cout, output, 1, unsigned carry out of bit N-1 (for k=1: 1 = no borrow).

Function
REQ-015 FSM SHALL have states IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 IDLE: on clk edge with in_valid=1 and flush=0, SHALL latch a, b XOR {N{k}}, k; carry := k; slice index := 0; go RUN.
REQ-017 RUN: each cycle SHALL compute slice i = a[i*W+:W] + bx[i*W+:W] + carry, write result bits [i*W+:W], update carry, increment index.
REQ-018 After slice N/W-1, SHALL set s[N] = a[N-1] XOR bx[N-1] XOR final carry, cout := final carry, and go DONE.
REQ-019 Latency SHALL be exactly N/W cycles: out_valid rises N/W clock edges after the accepting edge (4 for defaults).
REQ-020 DONE: s and cout SHALL stay stable while out_ready=0; on out_ready=1 go IDLE (no same-cycle acceptance of a new request).
REQ-021 in_valid in RUN or DONE SHALL be ignored and not latched.
REQ-022 flush=1 SHALL force IDLE on the next edge from any state, dropping out_valid; flush wins over simultaneous in_valid or out_ready.
REQ-023 Slice index SHALL not wrap: RUN exits exactly on the last slice.
REQ-024 s and cout SHALL hold their last value in IDLE after a completed operation; flush SHALL clear them to 0.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, s=0, cout=0, out_valid=0, in_ready=1 (after release), index=0, carry=0.
REQ-026 Reset asserted mid-RUN SHALL discard the operation; the first request after release SHALL complete correctly.

Structure
REQ-027 Package addsub_pkg SHALL hold the state enum (IDLE, RUN, DONE) and default N, W constants.
REQ-028 One sub-module addsub_slice (W-bit combinational adder: a, b, cin -> sum, cout) SHALL be instantiated once and reused every RUN cycle.

Verification (N=64, W=16)
REQ-029 a=5, b=3, k=0 -> s=8, cout=0, out_valid exactly 4 cycles after accept.
REQ-030 a=5, b=7, k=1 -> s=0x1_FFFF_FFFF_FFFF_FFFE (-2), cout=0.
REQ-031 a=0x7FFF_FFFF_FFFF_FFFF, b=1, k=0 -> s=0x0_8000_0000_0000_0000 (+2^63), cout=0, carry rippled through all 4 slices.
REQ-032 a=0x8000_0000_0000_0000, b=1, k=1 -> s=0x1_7FFF_FFFF_FFFF_FFFF (-2^63-1), cout=1.
REQ-033 out_ready held 0 for 3 cycles in DONE while in_valid=1 with new operands -> s unchanged, in_ready=0, new request not taken; IDLE one edge after out_ready=1.
REQ-034 rst_n pulsed low after 2 RUN cycles (and separately flush=1 in RUN) -> s=0, out_valid=0, in_ready=1; next request a=10, b=4, k=1 -> s=6.
